// File: rtl/instruction_fetcher_pkg.sv
// Shared definitions for the instruction fetcher: RISC-V opcodes, fetch FSM
// states and the branch-history counter helpers.
package instruction_fetcher_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Counters start weakly not-taken so one taken outcome is enough to flip them.
  localparam logic [1:0] BHT_RESET = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HOLD,
    ST_DISCARD
  } fetch_state_t;

  // Only conditional branches consult the predictor.
  function automatic logic is_branch(input logic [31:0] word);
    return word[6:0] == OP_BRANCH;
  endfunction

  // Two-bit saturating counter step.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/instruction_fetcher_if.sv
// Bus bundle of the fetcher: memory-controller handshake, decoder handshake,
// RoB flush and RoB branch-outcome feedback.
interface instruction_fetcher_if;

  // memory controller
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;

  // decoder
  logic        fetch_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        pred_res;
  logic        issue_ready;
  logic        pc_change_flag;
  logic [31:0] pc_change;

  // reorder buffer
  logic        flush;
  logic [31:0] flush_pc;
  logic        bht_update;
  logic [31:0] bht_pc;
  logic        bht_taken;

  // fetcher side
  modport master (
    output mem_req, mem_addr, fetch_ready, inst, pc, pred_res,
    input  mem_done, mem_data, issue_ready, pc_change_flag, pc_change,
    input  flush, flush_pc, bht_update, bht_pc, bht_taken
  );

  // environment side (memory, decoder, RoB)
  modport slave (
    input  mem_req, mem_addr, fetch_ready, inst, pc, pred_res,
    output mem_done, mem_data, issue_ready, pc_change_flag, pc_change,
    output flush, flush_pc, bht_update, bht_pc, bht_taken
  );

endinterface

// File: rtl/instruction_fetcher_branch_predictor.sv
// Branch history table: 2^BHT_IDX_W two-bit saturating counters indexed by
// pc[BHT_IDX_W+1:2]. Combinational prediction read, synchronous update.
// A read and a write to the same entry in one cycle see the old value.
module instruction_fetcher_branch_predictor
  import instruction_fetcher_pkg::*;
#(
  parameter int BHT_IDX_W = 6
) (
  input  logic        clk_in,
  input  logic        rstn_in,
  input  logic        rdy_in,
  input  logic [31:0] pred_pc,
  output logic        pred_taken,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken
);

  localparam int ENTRIES = 1 << BHT_IDX_W;

  logic [BHT_IDX_W-1:0]        pred_idx;
  logic [BHT_IDX_W-1:0]        upd_idx;
  logic [ENTRIES-1:0][1:0]     ctr_vec;

  assign pred_idx = pred_pc[BHT_IDX_W+1:2];
  assign upd_idx  = upd_pc[BHT_IDX_W+1:2];

  // Byte offset and high PC bits do not select a counter.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[31:BHT_IDX_W+2], pred_pc[1:0],
                            upd_pc[31:BHT_IDX_W+2], upd_pc[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_ctr
      logic [1:0] ctr_reg;

      // Per-entry counter: steps on a committed branch that maps here.
      always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
          ctr_reg <= BHT_RESET;
        end else if (rdy_in && upd_en && (upd_idx == BHT_IDX_W'(gi))) begin
          ctr_reg <= sat_update(ctr_reg, upd_taken);
        end
      end

      assign ctr_vec[gi] = ctr_reg;
    end
  endgenerate

  // Upper counter bit is the taken prediction.
  assign pred_taken = ctr_vec[pred_idx][1];

endmodule

// File: rtl/instruction_fetcher.sv
// Instruction fetch stage: owns the fetch PC, issues one word request at a
// time, buffers the returned word with its branch prediction until the
// decoder takes it, and redirects on decoder jumps and RoB flushes.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int          BHT_IDX_W = 6,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic                   clk_in,
  input  logic                   rstn_in,
  input  logic                   rdy_in,
  instruction_fetcher_if.master  bus
);

  fetch_state_t state_reg, state_next;

  logic [31:0] fetch_pc_reg,    fetch_pc_next;
  logic        fetch_ready_reg, fetch_ready_next;
  logic [31:0] inst_reg,        inst_next;
  logic [31:0] pc_reg,          pc_next;
  logic        pred_reg,        pred_next;
  logic        mem_req_reg,     mem_req_next;
  logic [31:0] mem_addr_reg,    mem_addr_next;

  logic        bht_pred;

  instruction_fetcher_branch_predictor #(
    .BHT_IDX_W (BHT_IDX_W)
  ) u_branch_predictor (
    .clk_in     (clk_in),
    .rstn_in    (rstn_in),
    .rdy_in     (rdy_in),
    .pred_pc    (fetch_pc_reg),
    .pred_taken (bht_pred),
    .upd_en     (bus.bht_update),
    .upd_pc     (bus.bht_pc),
    .upd_taken  (bus.bht_taken)
  );

  // State register; a low global ready freezes the FSM.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_reg <= ST_IDLE;
    end else if (rdy_in) begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; flush beats every other event.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        state_next = bus.flush ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.flush) begin
          // A request already in flight must still be drained.
          state_next = bus.mem_done ? ST_IDLE : ST_DISCARD;
        end else if (bus.mem_done) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.flush || bus.issue_ready) begin
          state_next = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (bus.mem_done) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Next values of fetch PC, output buffer and memory request.
  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    fetch_ready_next = fetch_ready_reg;
    inst_next        = inst_reg;
    pc_next          = pc_reg;
    pred_next        = pred_reg;
    mem_req_next     = mem_req_reg;
    mem_addr_next    = mem_addr_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (bus.flush) begin
          fetch_pc_next    = bus.flush_pc;
          fetch_ready_next = 1'b0;
        end else begin
          mem_req_next  = 1'b1;
          mem_addr_next = fetch_pc_reg;
        end
      end
      ST_WAIT: begin
        if (bus.flush) begin
          fetch_pc_next = bus.flush_pc;
          if (bus.mem_done) begin
            mem_req_next = 1'b0;
          end
        end else if (bus.mem_done) begin
          inst_next        = bus.mem_data;
          pc_next          = fetch_pc_reg;
          pred_next        = is_branch(bus.mem_data) && bht_pred;
          fetch_ready_next = 1'b1;
          mem_req_next     = 1'b0;
        end
      end
      ST_HOLD: begin
        if (bus.flush) begin
          fetch_ready_next = 1'b0;
          fetch_pc_next    = bus.flush_pc;
        end else if (bus.issue_ready) begin
          fetch_ready_next = 1'b0;
          // JALR and not-taken branches fall through; the RoB repairs them.
          fetch_pc_next    = bus.pc_change_flag ? bus.pc_change : pc_reg + 32'd4;
        end
      end
      ST_DISCARD: begin
        if (bus.flush) begin
          fetch_pc_next = bus.flush_pc;
        end
        if (bus.mem_done) begin
          mem_req_next = 1'b0;
        end
      end
      default: begin
        fetch_ready_next = 1'b0;
        mem_req_next     = 1'b0;
      end
    endcase
  end

  // Datapath and output registers, frozen while rdy_in is low.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      fetch_pc_reg    <= RESET_PC;
      fetch_ready_reg <= 1'b0;
      inst_reg        <= 32'h0;
      pc_reg          <= 32'h0;
      pred_reg        <= 1'b0;
      mem_req_reg     <= 1'b0;
      mem_addr_reg    <= 32'h0;
    end else if (rdy_in) begin
      fetch_pc_reg    <= fetch_pc_next;
      fetch_ready_reg <= fetch_ready_next;
      inst_reg        <= inst_next;
      pc_reg          <= pc_next;
      pred_reg        <= pred_next;
      mem_req_reg     <= mem_req_next;
      mem_addr_reg    <= mem_addr_next;
    end
  end

  assign bus.mem_req     = mem_req_reg;
  assign bus.mem_addr    = mem_addr_reg;
  assign bus.fetch_ready = fetch_ready_reg;
  assign bus.inst        = inst_reg;
  assign bus.pc          = pc_reg;
  assign bus.pred_res    = pred_reg;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Scoreboard bench for instruction_fetcher: a memory model checks request
// addresses against an expected queue, and a monitor checks every issued
// instruction (pc, word, prediction) against a second expected queue.
module tb_instruction_fetcher;

  logic clk = 1'b0;
  logic rstn;
  logic rdy;

  always #5 clk = ~clk;

  instruction_fetcher_if bus();

  instruction_fetcher #(
    .BHT_IDX_W (6),
    .RESET_PC  (32'h0)
  ) dut (
    .clk_in  (clk),
    .rstn_in (rstn),
    .rdy_in  (rdy),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 3;

  // Program image; unmapped addresses read as NOP.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0010_0093; // addi x1,x0,1
      32'h0000_0004: return 32'h0020_0113; // addi x2,x0,2
      32'h0000_0008: return 32'h0f80_006f; // jal
      32'h0000_0100: return 32'h0030_0193; // addi x3,x0,3
      32'h0000_0020: return 32'h0020_8463; // beq (trained)
      32'h0000_0024: return 32'h0020_8663; // beq (untrained)
      32'h0000_0028: return 32'h0070_0393; // discarded by flush
      32'h0000_0200: return 32'h0040_0213; // addi x4,x0,4
      32'h0000_0204: return 32'h0050_0293; // addi x5,x0,5
      32'h0000_0300: return 32'h0060_0313; // addi x6,x0,6
      default:       return 32'h0000_0013;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] p, input logic [31:0] w, input logic pr);
    exp_t e;
    e.pc = p; e.inst = w; e.pred = pr;
    exp_q.push_back(e);
  endtask

  // Bounded wait (at negedges) for the output buffer to fill.
  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!bus.fetch_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    ok = bus.fetch_ready;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL fetch_ready_timeout actual=0 required=1");
    end
  endtask

  // Wait for a word, optionally stall the decoder, then issue it for one cycle.
  task automatic consume(input int hold, input bit chg, input logic [31:0] tgt,
                         input bit fl, input logic [31:0] fpc);
    bit ok;
    logic [31:0] inst_s, pc_s;
    wait_ready(ok);
    if (!ok) return;
    inst_s = bus.inst;
    pc_s   = bus.pc;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_fetch_ready", 32'(bus.fetch_ready), 32'd1);
      check("hold_inst", bus.inst, inst_s);
      check("hold_pc", bus.pc, pc_s);
      check("hold_mem_req", 32'(bus.mem_req), 32'd0);
    end
    bus.issue_ready    = 1'b1;
    bus.pc_change_flag = chg;
    bus.pc_change      = tgt;
    bus.flush          = fl;
    bus.flush_pc       = fpc;
    @(negedge clk);
    bus.issue_ready    = 1'b0;
    bus.pc_change_flag = 1'b0;
    bus.flush          = 1'b0;
  endtask

  // Memory controller model: checks the request address, answers after mem_lat cycles.
  initial begin
    logic [31:0] req_addr;
    int lat;
    bus.mem_done = 1'b0;
    bus.mem_data = 32'h0;
    forever begin
      @(negedge clk);
      if (rstn && bus.mem_req) begin
        req_addr = bus.mem_addr;
        lat      = mem_lat;
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_addr_unexpected actual=%h required=none", req_addr);
        end else begin
          check("mem_addr", req_addr, addr_q.pop_front());
        end
        repeat (lat - 1) @(negedge clk);
        bus.mem_data = mem_word(req_addr);
        bus.mem_done = 1'b1;
        $display("mem    addr=%h data=%h", req_addr, bus.mem_data);
        @(negedge clk);
        bus.mem_done = 1'b0;
      end
    end
  end

  // Monitor: every accepted issue is compared with the next expected word.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rstn && rdy && bus.fetch_ready && bus.issue_ready) begin
        exp_t e;
        $display("issue  pc=%h inst=%h pred=%0d", bus.pc, bus.inst, bus.pred_res);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected actual=%h required=none", bus.pc);
        end else begin
          e = exp_q.pop_front();
          check("issue_pc", bus.pc, e.pc);
          check("issue_inst", bus.inst, e.inst);
          check("issue_pred", 32'(bus.pred_res), 32'(e.pred));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    rstn = 1'b0;
    rdy  = 1'b1;
    bus.issue_ready    = 1'b0;
    bus.pc_change_flag = 1'b0;
    bus.pc_change      = 32'h0;
    bus.flush          = 1'b0;
    bus.flush_pc       = 32'h0;
    bus.bht_update     = 1'b0;
    bus.bht_pc         = 32'h0;
    bus.bht_taken      = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_fetch_ready", 32'(bus.fetch_ready), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_pc", bus.pc, 32'h0);
    check("rst_pred", 32'(bus.pred_res), 32'd0);
    rstn = 1'b1;

    // Sequential fetch, then a held word, then a JAL redirect.
    addr_q.push_back(32'h0);
    addr_q.push_back(32'h4);
    addr_q.push_back(32'h8);
    addr_q.push_back(32'h100);
    push_exp(32'h0, 32'h0010_0093, 1'b0);
    consume(0, 1'b0, 32'h0, 1'b0, 32'h0);
    push_exp(32'h4, 32'h0020_0113, 1'b0);
    consume(5, 1'b0, 32'h0, 1'b0, 32'h0);
    push_exp(32'h8, 32'h0f80_006f, 1'b0);
    consume(0, 1'b1, 32'h100, 1'b0, 32'h0);

    // Train 0x20 taken twice while the 0x100 fetch is in flight.
    bus.bht_update = 1'b1;
    bus.bht_pc     = 32'h20;
    bus.bht_taken  = 1'b1;
    repeat (2) @(negedge clk);
    bus.bht_update = 1'b0;

    addr_q.push_back(32'h20);
    push_exp(32'h100, 32'h0030_0193, 1'b0);
    consume(0, 1'b1, 32'h20, 1'b0, 32'h0);
    addr_q.push_back(32'h24);
    push_exp(32'h20, 32'h0020_8463, 1'b1);
    consume(0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Flush two cycles into a 4-cycle wait: the 0x28 word must be dropped.
    mem_lat = 4;
    addr_q.push_back(32'h28);
    addr_q.push_back(32'h200);
    push_exp(32'h24, 32'h0020_8663, 1'b0);
    consume(0, 1'b0, 32'h0, 1'b0, 32'h0);
    n = 0;
    while (!bus.mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("flush_req_seen", 32'(bus.mem_req), 32'd1);
    @(negedge clk);
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h200;
    @(negedge clk);
    bus.flush    = 1'b0;
    n = 0;
    while (!(bus.mem_req && bus.mem_addr == 32'h200) && n < 20) begin
      check("discard_fetch_ready", 32'(bus.fetch_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    check("flush_restart_addr", bus.mem_addr, 32'h200);

    // Flush wins over a simultaneous issue with decoder redirect.
    addr_q.push_back(32'h204);
    addr_q.push_back(32'h300);
    push_exp(32'h200, 32'h0040_0213, 1'b0);
    consume(0, 1'b0, 32'h0, 1'b0, 32'h0);
    push_exp(32'h204, 32'h0050_0293, 1'b0);
    consume(0, 1'b1, 32'h100, 1'b1, 32'h300);

    // rdy_in low freezes the buffer even with issue_ready asserted.
    wait_ready(ok);
    if (ok) begin
      rdy = 1'b0;
      bus.issue_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("stall_fetch_ready", 32'(bus.fetch_ready), 32'd1);
        check("stall_pc", bus.pc, 32'h300);
        check("stall_mem_req", 32'(bus.mem_req), 32'd0);
      end
      rdy = 1'b1;
      bus.issue_ready = 1'b0;
    end
    addr_q.push_back(32'h304);
    push_exp(32'h300, 32'h0060_0313, 1'b0);
    consume(0, 1'b0, 32'h0, 1'b0, 32'h0);

    repeat (8) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("addr_q_drained", 32'(addr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
